// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - single-port word memory behind a start/pulse bus with fixed wait states
// Illegal (misaligned or out-of-range) accesses still complete, flagged with BUS_err.
module bus_responder #(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        BUS_start_transaction,
   input  logic        BUS_mode,
   input  logic [31:0] BUS_addr,
   input  logic [31:0] BUS_wdata,
   output logic [31:0] BUS_rdata,
   output logic        BUS_rdata_valid,
   output logic        BUS_write_done,
   output logic        BUS_err,
   output logic        BUS_busy
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS
   } state_t;

   state_t        state;
   logic [3:0]    cnt;
   logic          mode_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   mem [DEPTH];
   logic          legal;
   logic [AW-1:0] idx;

   assign legal = (addr_q[1:0] == 2'b00) && (addr_q[31:2] < 30'(DEPTH));
   assign idx   = addr_q[AW+1:2];

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_IDLE;
         cnt             <= 4'd0;
         mode_q          <= 1'b0;
         addr_q          <= 32'd0;
         wdata_q         <= 32'd0;
         BUS_rdata       <= 32'd0;
         BUS_rdata_valid <= 1'b0;
         BUS_write_done  <= 1'b0;
         BUS_err         <= 1'b0;
         BUS_busy        <= 1'b0;
      end else begin
         BUS_rdata_valid <= 1'b0;
         BUS_write_done  <= 1'b0;
         BUS_err         <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (BUS_start_transaction) begin
                  mode_q   <= BUS_mode;
                  addr_q   <= BUS_addr;
                  wdata_q  <= BUS_wdata;
                  cnt      <= 4'(WAIT_CYCLES);
                  state    <= (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                  BUS_busy <= 1'b1;
               end
            end
            ST_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               state    <= ST_IDLE;
               BUS_busy <= 1'b0;
               BUS_err  <= ~legal;
               if (mode_q) begin
                  BUS_write_done <= 1'b1;
               end else begin
                  BUS_rdata_valid <= 1'b1;
                  BUS_rdata       <= legal ? mem[idx] : 32'd0;
               end
            end
            default: begin
               state    <= ST_IDLE;
               BUS_busy <= 1'b0;
            end
         endcase
      end
   end

   // Reset in ACCESS must also suppress the write, so rst gates it here too.
   always_ff @(posedge clk) begin
      if (!rst && state == ST_ACCESS && mode_q && legal) begin
         mem[idx] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_bus_responder.sv
// tb/tb_bus_responder.sv - directed vector bench for bus_responder (WAIT_CYCLES=2 and 0 builds)
module tb_bus_responder;

   localparam int WC    = 2;
   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, mode = 1'b0;
   logic [31:0] addr = 32'd0, wdata = 32'd0;
   logic [31:0] rdata;
   logic        valid, done, err, busy;

   logic        z_start = 1'b0, z_mode = 1'b0;
   logic [31:0] z_addr = 32'd0, z_wdata = 32'd0;
   logic [31:0] z_rdata;
   logic        z_valid, z_done, z_err, z_busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_rv = 0;
   int n_wd = 0;
   logic [31:0] last_rd = 32'd0;

   bus_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
      .clk(clk), .rst(rst),
      .BUS_start_transaction(start), .BUS_mode(mode), .BUS_addr(addr), .BUS_wdata(wdata),
      .BUS_rdata(rdata), .BUS_rdata_valid(valid), .BUS_write_done(done),
      .BUS_err(err), .BUS_busy(busy)
   );

   bus_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst),
      .BUS_start_transaction(z_start), .BUS_mode(z_mode), .BUS_addr(z_addr), .BUS_wdata(z_wdata),
      .BUS_rdata(z_rdata), .BUS_rdata_valid(z_valid), .BUS_write_done(z_done),
      .BUS_err(z_err), .BUS_busy(z_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Pulse exclusivity and err-only-with-pulse, every cycle, both builds.
   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if ((valid && done) || (err && !valid && !done) ||
             (z_valid && z_done) || (z_err && !z_valid && !z_done)) begin
            errors++;
            $display("FAIL pulse_excl at cycle %0d: valid=%b done=%b err=%b z_valid=%b z_done=%b z_err=%b",
                     cyc, valid, done, err, z_valid, z_done, z_err);
         end
         if (valid) n_rv++;
         if (done)  n_wd++;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic run_txn(input logic m, input logic [31:0] a, input logic [31:0] w,
                          input logic [31:0] er, input logic ee, input int id);
      int k;
      int g;
      @(negedge clk);
      start = 1'b1; mode = m; addr = a; wdata = w;
      k = cyc + 1;
      @(negedge clk);
      start = 1'b0; mode = ~m; addr = ~a; wdata = ~w;
      chk1($sformatf("v%0d_busy", id), busy, 1'b1);
      g = 0;
      while (!(valid || done) && g < 20) begin
         @(negedge clk);
         g++;
      end
      chk1($sformatf("v%0d_timeout", id), (g < 20), 1'b1);
      chk32($sformatf("v%0d_latency", id), 32'(cyc), 32'(k + WC + 1));
      chk1($sformatf("v%0d_valid", id), valid, ~m);
      chk1($sformatf("v%0d_done", id), done, m);
      chk1($sformatf("v%0d_err", id), err, ee);
      chk1($sformatf("v%0d_busy_pulse", id), busy, 1'b0);
      if (!m) last_rd = er;
      chk32($sformatf("v%0d_rdata", id), rdata, last_rd);
      @(negedge clk);
      chk1($sformatf("v%0d_valid_after", id), valid, 1'b0);
      chk1($sformatf("v%0d_done_after", id), done, 1'b0);
   endtask

   typedef struct {
      logic        mode;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[13];

   initial begin
      int k;
      int g;
      int rv0;
      int wd0;

      vecs[0]  = '{1'b1, 32'h0000_0020, 32'h1111_1111, 32'h0, 1'b0};
      vecs[1]  = '{1'b1, 32'h0000_0030, 32'hA5A5_A5A5, 32'h0, 1'b0};
      vecs[2]  = '{1'b1, 32'h0000_0000, 32'h0BAD_CAFE, 32'h0, 1'b0};
      vecs[3]  = '{1'b0, 32'h0000_0013, 32'h0,         32'h0, 1'b1};
      vecs[4]  = '{1'b0, 32'h0000_0400, 32'h0,         32'h0, 1'b1};
      vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[6]  = '{1'b1, 32'h0000_0400, 32'h1234_5678, 32'h0, 1'b1};
      vecs[7]  = '{1'b1, 32'h0000_0002, 32'h8765_4321, 32'h0, 1'b1};
      vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0BAD_CAFE, 1'b0};
      vecs[9]  = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0, 1'b0};
      vecs[10] = '{1'b0, 32'h0000_03FC, 32'h0,         32'hCAFE_F00D, 1'b0};
      vecs[11] = '{1'b0, 32'h0000_0020, 32'h0,         32'h1111_1111, 1'b0};
      vecs[12] = '{1'b0, 32'hFFFF_FFF0, 32'h0,         32'h0, 1'b1};

      // Reset with a start held high: nothing may be accepted.
      start = 1'b1; mode = 1'b1; addr = 32'h10; wdata = 32'hFFFF_FFFF;
      repeat (3) @(negedge clk);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_valid", valid, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_err", err, 1'b0);
      chk32("rst_rdata", rdata, 32'h0);
      chk1("rst_z_busy", z_busy, 1'b0);
      chk32("rst_z_rdata", z_rdata, 32'h0);

      // First edge with rst low accepts the write; read follows in the pulse cycle.
      rst = 1'b0; start = 1'b1; mode = 1'b1; addr = 32'h10; wdata = 32'hDEAD_BEEF;
      k = cyc + 1;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         if (n == 0) begin
            start = 1'b0; mode = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h0;
         end
         chk1($sformatf("a_busy_%0d", n), busy, 1'b1);
         chk1($sformatf("a_nopulse_%0d", n), valid | done, 1'b0);
      end
      @(negedge clk);
      chk32("a_wr_latency", 32'(cyc), 32'(k + 3));
      chk1("a_wr_done", done, 1'b1);
      chk1("a_wr_err", err, 1'b0);
      chk1("a_wr_busy", busy, 1'b0);
      start = 1'b1; mode = 1'b0; addr = 32'h10;
      @(negedge clk);
      start = 1'b0;
      chk1("a_rd_busy", busy, 1'b1);
      chk1("a_wr_done_low", done, 1'b0);
      g = 0;
      while (!valid && g < 20) begin
         @(negedge clk);
         g++;
      end
      chk32("a_rd_latency", 32'(cyc), 32'(k + 2 * (WC + 2) - 1));
      chk32("a_rd_data", rdata, 32'hDEAD_BEEF);
      chk1("a_rd_err", err, 1'b0);
      last_rd = 32'hDEAD_BEEF;
      @(negedge clk);
      chk1("a_rd_valid_low", valid, 1'b0);

      for (int i = 0; i < 13; i++) begin
         run_txn(vecs[i].mode, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, i);
      end

      // Repeated starts while busy (write 0x20 <= 1) must be ignored.
      @(negedge clk);
      rv0 = n_rv; wd0 = n_wd;
      start = 1'b1; mode = 1'b0; addr = 32'h10;
      k = cyc + 1;
      @(negedge clk);
      mode = 1'b1; addr = 32'h20; wdata = 32'h1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk32("b_latency", 32'(cyc), 32'(k + WC + 1));
      chk1("b_valid", valid, 1'b1);
      chk32("b_rdata", rdata, 32'hDEAD_BEEF);
      last_rd = 32'hDEAD_BEEF;
      repeat (5) @(negedge clk);
      chk1("b_idle", busy, 1'b0);
      chk32("b_rv_count", 32'(n_rv - rv0), 32'd1);
      chk32("b_wd_count", 32'(n_wd - wd0), 32'd0);
      run_txn(1'b0, 32'h20, 32'h0, 32'h1111_1111, 1'b0, 20);

      // Reset at the edge that would complete the write aborts it.
      @(negedge clk);
      rv0 = n_rv; wd0 = n_wd;
      start = 1'b1; mode = 1'b1; addr = 32'h30; wdata = 32'h55AA_55AA;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk1("c_busy_before", busy, 1'b1);
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      chk1("c_busy", busy, 1'b0);
      chk1("c_done", done, 1'b0);
      chk1("c_valid", valid, 1'b0);
      chk32("c_rdata", rdata, 32'h0);
      rst = 1'b0; start = 1'b0;
      last_rd = 32'h0;
      @(negedge clk);
      chk1("c_same_edge_start", busy, 1'b0);
      repeat (4) @(negedge clk);
      chk32("c_pulses", 32'((n_rv - rv0) + (n_wd - wd0)), 32'd0);
      run_txn(1'b0, 32'h30, 32'h0, 32'hA5A5_A5A5, 1'b0, 21);

      // Zero-wait build: pulse one edge after acceptance, back-to-back.
      @(negedge clk);
      z_start = 1'b1; z_mode = 1'b1; z_addr = 32'h0; z_wdata = 32'h1357_9BDF;
      @(negedge clk);
      z_start = 1'b0; z_wdata = 32'h0;
      chk1("z_wr_busy", z_busy, 1'b1);
      chk1("z_wr_early", z_done, 1'b0);
      @(negedge clk);
      chk1("z_wr_done", z_done, 1'b1);
      chk1("z_wr_err", z_err, 1'b0);
      chk1("z_wr_idle", z_busy, 1'b0);
      z_start = 1'b1; z_mode = 1'b0; z_addr = 32'h0;
      @(negedge clk);
      z_start = 1'b0;
      chk1("z_rd_busy", z_busy, 1'b1);
      chk1("z_rd_early", z_valid, 1'b0);
      @(negedge clk);
      chk1("z_rd_valid", z_valid, 1'b1);
      chk32("z_rd_data", z_rdata, 32'h1357_9BDF);
      chk1("z_rd_err", z_err, 1'b0);
      @(negedge clk);
      chk1("z_rd_valid_low", z_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
